// File: rtl/password_check_pkg.sv
// Shared definitions for the password store / password check pair.
package password_check_pkg;

    localparam int unsigned PWD_DIGIT_W = 4;
    localparam int unsigned PWD_LEN     = 4;

    typedef logic [PWD_DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_EVAL,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

endpackage

// File: rtl/password_check_if.sv
// Keypad, stored-password and status signals of the password checker.
interface password_check_if;
    import password_check_pkg::*;

    logic       check;
    logic       enable;
    digit_t     keyValue;
    digit_t     pwd0;
    digit_t     pwd1;
    digit_t     pwd2;
    digit_t     pwd3;
    logic       unlock;
    logic       alarm;
    logic       err;
    logic [2:0] fail_cnt;
    logic [2:0] digit_cnt;

    modport master (
        output check, enable, keyValue, pwd0, pwd1, pwd2, pwd3,
        input  unlock, alarm, err, fail_cnt, digit_cnt
    );

    modport slave (
        input  check, enable, keyValue, pwd0, pwd1, pwd2, pwd3,
        output unlock, alarm, err, fail_cnt, digit_cnt
    );
endinterface

// File: rtl/password_check_hold_timer.sv
// Loadable down-counter that stops at zero; shared by OPEN and LOCKOUT.
module hold_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_value,
    input  logic             run,
    output logic             zero
);
    logic [TMR_W-1:0] count;

    // Load has priority; otherwise count down while running, holding at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run && count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/password_check.sv
// Collects a 4-digit attempt, compares it with the stored password and
// drives a timed unlock or, after repeated failures, a timed lockout.
module password_check
    import password_check_pkg::*;
#(
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned UNLOCK_CYCLES = 500,
    parameter int unsigned LOCK_CYCLES   = 1000,
    parameter int unsigned TMR_W         = 16
) (
    input logic             clk,
    input logic             rst,
    password_check_if.slave bus
);
    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);

    state_t           state;
    digit_t           entry [PWD_LEN];
    digit_t           pwd   [PWD_LEN];
    logic             match;
    logic             lock_next;
    logic             tmr_load;
    logic             tmr_run;
    logic             tmr_zero;
    logic [TMR_W-1:0] tmr_value;
    logic             unlock_r;
    logic             alarm_r;
    logic             err_r;
    logic [2:0]       fail_cnt_r;
    logic [2:0]       digit_cnt_r;

    assign pwd[0] = bus.pwd0;
    assign pwd[1] = bus.pwd1;
    assign pwd[2] = bus.pwd2;
    assign pwd[3] = bus.pwd3;

    // Whole-attempt comparison against the live stored digits.
    always_comb begin
        match = 1'b1;
        for (int unsigned i = 0; i < PWD_LEN; i++) begin
            if (entry[i] != pwd[i]) begin
                match = 1'b0;
            end
        end
    end

    assign lock_next = (fail_cnt_r + 3'd1) == MAX_FAIL_C;
    assign tmr_load  = (state == ST_EVAL) && (match || lock_next);
    assign tmr_value = match ? TMR_W'(UNLOCK_CYCLES - 1) : TMR_W'(LOCK_CYCLES - 1);
    assign tmr_run   = (state == ST_OPEN) || (state == ST_LOCKOUT);

    hold_timer #(.TMR_W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .run        (tmr_run),
        .zero       (tmr_zero)
    );

    // Main controller: entry capture, evaluation, and timed open/lockout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            unlock_r    <= 1'b0;
            alarm_r     <= 1'b0;
            err_r       <= 1'b0;
            fail_cnt_r  <= '0;
            digit_cnt_r <= '0;
            for (int unsigned i = 0; i < PWD_LEN; i++) entry[i] <= '0;
        end else begin
            err_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.check && bus.enable) begin
                        entry[0]    <= bus.keyValue;
                        digit_cnt_r <= 3'd1;
                        state       <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (!bus.check) begin
                        for (int unsigned i = 0; i < PWD_LEN; i++) entry[i] <= '0;
                        digit_cnt_r <= '0;
                        state       <= ST_IDLE;
                    end else if (bus.enable) begin
                        entry[digit_cnt_r[1:0]] <= bus.keyValue;
                        digit_cnt_r             <= digit_cnt_r + 3'd1;
                        if (digit_cnt_r == 3'(PWD_LEN - 1)) begin
                            state <= ST_EVAL;
                        end
                    end
                end
                ST_EVAL: begin
                    for (int unsigned i = 0; i < PWD_LEN; i++) entry[i] <= '0;
                    digit_cnt_r <= '0;
                    if (match) begin
                        state      <= ST_OPEN;
                        unlock_r   <= 1'b1;
                        fail_cnt_r <= '0;
                    end else if (lock_next) begin
                        state      <= ST_LOCKOUT;
                        alarm_r    <= 1'b1;
                        fail_cnt_r <= MAX_FAIL_C;
                    end else begin
                        state      <= ST_IDLE;
                        err_r      <= 1'b1;
                        fail_cnt_r <= fail_cnt_r + 3'd1;
                    end
                end
                ST_OPEN: begin
                    if (tmr_zero) begin
                        state    <= ST_IDLE;
                        unlock_r <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_zero) begin
                        state      <= ST_IDLE;
                        alarm_r    <= 1'b0;
                        fail_cnt_r <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.unlock    = unlock_r;
    assign bus.alarm     = alarm_r;
    assign bus.err       = err_r;
    assign bus.fail_cnt  = fail_cnt_r;
    assign bus.digit_cnt = digit_cnt_r;
endmodule

// File: tb/tb_password_check.sv
// Randomized self-checking bench for password_check with an attempt-level model.
module tb_password_check;
    localparam int unsigned MAX_FAIL      = 3;
    localparam int unsigned UNLOCK_CYCLES = 500;
    localparam int unsigned LOCK_CYCLES   = 1000;

    logic clk = 1'b0;
    logic rst;

    password_check_if bus ();

    password_check #(
        .MAX_FAIL      (MAX_FAIL),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCK_CYCLES   (LOCK_CYCLES),
        .TMR_W         (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Model: stored password (digit i at bits 4i+3:4i) and consecutive failures.
    logic [15:0] pwd_m;
    int unsigned fails_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_pwd(input logic [15:0] v);
        pwd_m    = v;
        bus.pwd0 = v[3:0];
        bus.pwd1 = v[7:4];
        bus.pwd2 = v[11:8];
        bus.pwd3 = v[15:12];
    endtask

    task automatic strobe(input logic [3:0] d);
        bus.check    = 1'b1;
        bus.enable   = 1'b1;
        bus.keyValue = d;
        @(negedge clk);
        bus.enable   = 1'b0;
    endtask

    // Run through a hold period with random keypad noise; returns its length.
    task automatic hold_run(input bit is_lock, output int unsigned n);
        n = 0;
        while (((is_lock ? bus.alarm : bus.unlock) === 1'b1) && n < 3000) begin
            n++;
            bus.check    = 1'($urandom_range(0, 1));
            bus.enable   = 1'($urandom_range(0, 1));
            bus.keyValue = 4'($urandom);
            @(negedge clk);
            check_eq("hold_digit_cnt", bus.digit_cnt, 0);
        end
        bus.enable = 1'b0;
        bus.check  = 1'b1;
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b0;
        #1;
        check_eq("rst_unlock", bus.unlock, 0);
        check_eq("rst_alarm", bus.alarm, 0);
        check_eq("rst_fail_cnt", bus.fail_cnt, 0);
        check_eq("rst_digit_cnt", bus.digit_cnt, 0);
        @(negedge clk);
        rst     = 1'b1;
        fails_m = 0;
    endtask

    task automatic abort_partial(input logic [15:0] att, input int unsigned k);
        for (int i = 0; i < int'(k); i++) strobe(att[4*i +: 4]);
        bus.check = 1'b0;
        @(negedge clk);
        check_eq("abort_digit_cnt", bus.digit_cnt, 0);
        check_eq("abort_fail_cnt", bus.fail_cnt, fails_m);
        check_eq("abort_err", bus.err, 0);
        bus.check = 1'b1;
    endtask

    // One full attempt; rst_after>0 resets asynchronously that many cycles into the hold.
    task automatic do_attempt(input logic [15:0] att, input bit eval_junk, input int unsigned rst_after);
        int unsigned n;
        int unsigned gap;
        for (int i = 0; i < 4; i++) begin
            strobe(att[4*i +: 4]);
            check_eq("entry_digit_cnt", bus.digit_cnt, i + 1);
            if (i < 3) begin
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
            end
        end
        check_eq("eval_outputs_quiet", {bus.unlock, bus.alarm, bus.err}, 0);
        if (eval_junk) begin
            bus.enable   = 1'b1;
            bus.keyValue = 4'($urandom);
        end
        @(negedge clk);
        bus.enable = 1'b0;
        check_eq("post_eval_digit_cnt", bus.digit_cnt, 0);
        if (att == pwd_m) begin
            fails_m = 0;
            check_eq("open_unlock", bus.unlock, 1);
            check_eq("open_alarm", bus.alarm, 0);
            check_eq("open_err", bus.err, 0);
            check_eq("open_fail_cnt", bus.fail_cnt, 0);
            if (rst_after > 0) begin
                repeat (rst_after) @(negedge clk);
                async_reset_check();
            end else begin
                hold_run(1'b0, n);
                check_eq("unlock_len", n, UNLOCK_CYCLES);
                check_eq("after_open_fail_cnt", bus.fail_cnt, 0);
            end
        end else if (fails_m + 1 == MAX_FAIL) begin
            check_eq("lock_alarm", bus.alarm, 1);
            check_eq("lock_unlock", bus.unlock, 0);
            check_eq("lock_err", bus.err, 0);
            check_eq("lock_fail_cnt", bus.fail_cnt, MAX_FAIL);
            if (rst_after > 0) begin
                repeat (rst_after) @(negedge clk);
                async_reset_check();
            end else begin
                hold_run(1'b1, n);
                check_eq("alarm_len", n, LOCK_CYCLES);
                fails_m = 0;
                check_eq("after_lock_fail_cnt", bus.fail_cnt, 0);
            end
        end else begin
            fails_m++;
            check_eq("err_pulse", bus.err, 1);
            check_eq("err_unlock", bus.unlock, 0);
            check_eq("err_alarm", bus.alarm, 0);
            check_eq("err_fail_cnt", bus.fail_cnt, fails_m);
            @(negedge clk);
            check_eq("err_one_cycle", bus.err, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] att;
        int unsigned kind;
        bus.check    = 1'b0;
        bus.enable   = 1'b0;
        bus.keyValue = '0;
        set_pwd(16'h4321);
        fails_m = 0;
        rst     = 1'b0;
        #2;
        check_eq("reset_unlock", bus.unlock, 0);
        check_eq("reset_alarm", bus.alarm, 0);
        check_eq("reset_err", bus.err, 0);
        check_eq("reset_fail_cnt", bus.fail_cnt, 0);
        check_eq("reset_digit_cnt", bus.digit_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Strobes without check mode are ignored.
        bus.check    = 1'b0;
        bus.enable   = 1'b1;
        bus.keyValue = 4'd1;
        @(negedge clk);
        bus.enable = 1'b0;
        check_eq("idle_no_check_digit_cnt", bus.digit_cnt, 0);
        bus.check = 1'b1;

        do_attempt(16'h4321, 1'b0, 0);   // correct
        do_attempt(16'h5321, 1'b0, 0);   // wrong
        do_attempt(16'h5321, 1'b1, 0);   // wrong
        do_attempt(16'h0000, 1'b0, 0);   // third wrong: lockout
        do_attempt(16'h4321, 1'b0, 0);   // unlocks after expiry

        do_attempt(16'h1111, 1'b0, 0);
        do_attempt(16'h2222, 1'b0, 0);
        do_attempt(16'h4321, 1'b0, 0);   // clears failures
        do_attempt(16'h4322, 1'b0, 0);   // back to one failure, no lockout
        do_attempt(16'h4321, 1'b0, 0);

        abort_partial(16'h4321, 2);
        do_attempt(16'h4321, 1'b0, 0);

        do_attempt(16'h4321, 1'b0, 37);  // reset mid-open
        do_attempt(16'h9999, 1'b0, 0);
        do_attempt(16'h9999, 1'b0, 0);
        do_attempt(16'h9999, 1'b0, 200); // reset mid-lockout
        check_eq("after_rst_idle_digit_cnt", bus.digit_cnt, 0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) set_pwd(16'($urandom));
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                att = pwd_m;
            end else if (kind < 8) begin
                att = pwd_m;
                att[4*$urandom_range(0, 3) +: 4] ^= 4'($urandom_range(1, 15));
            end else begin
                abort_partial(16'($urandom), $urandom_range(1, 3));
                att = 16'($urandom);
            end
            do_attempt(att, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
